// File: rtl/harris_corner_select.sv
// Keeps the strongest above-threshold Harris corners of each frame, with proximity
// suppression, and publishes the sorted list on the falling edge of VGA_VS.
module harris_corner_select #(
    parameter int P_R_BITS      = 16,
    parameter int P_NUM_CORNERS = 4,
    parameter int P_THRESH      = 40,
    parameter int P_RADIUS      = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 VGA_VS,
    input  logic                                 r_valid,
    input  logic signed [P_R_BITS-1:0]           r_value,
    input  logic [9:0]                           r_x,
    input  logic [9:0]                           r_y,
    output logic [10*P_NUM_CORNERS-1:0]          corner_x,
    output logic [10*P_NUM_CORNERS-1:0]          corner_y,
    output logic [$clog2(P_NUM_CORNERS+1)-1:0]   corner_count,
    output logic                                 frame_done
);

    localparam int N  = P_NUM_CORNERS;
    localparam int CW = $clog2(P_NUM_CORNERS + 1);
    localparam logic signed [P_R_BITS-1:0] THRESH_R = P_THRESH[P_R_BITS-1:0];
    localparam logic [10:0] RADIUS_R = 11'(P_RADIUS);

    typedef enum logic [1:0] {IDLE, SCAN, PUBLISH} state_t;

    state_t state_q, state_d;
    logic   vs_q, vs_d;
    logic   vs_fall;

    logic [9:0]                 ent_x_q [N];
    logic [9:0]                 ent_x_d [N];
    logic [9:0]                 ent_y_q [N];
    logic [9:0]                 ent_y_d [N];
    logic signed [P_R_BITS-1:0] ent_r_q [N];
    logic signed [P_R_BITS-1:0] ent_r_d [N];
    logic [CW-1:0]              count_q, count_d;

    logic [10*N-1:0] corner_x_q, corner_x_d;
    logic [10*N-1:0] corner_y_q, corner_y_d;
    logic [CW-1:0]   corner_count_q, corner_count_d;
    logic            frame_done_q, frame_done_d;

    logic [10:0]                dx [N];
    logic [10:0]                dy [N];
    logic                       is_cand;
    logic                       suppress;
    logic                       accept;
    logic [CW-1:0]              ins_k;
    logic [9:0]                 ins_x [N];
    logic [9:0]                 ins_y [N];
    logic signed [P_R_BITS-1:0] ins_r [N];
    logic [CW-1:0]              ins_count;

    assign vs_fall = vs_q & ~VGA_VS;

    // All entry compares run in parallel; the list is kept sorted strongest-first,
    // so the lowest winning slot is the insert position.
    always_comb begin
        is_cand  = r_valid && (r_value > THRESH_R);
        suppress = 1'b0;
        ins_k    = CW'(N);
        for (int i = 0; i < N; i++) begin
            dx[i] = (r_x >= ent_x_q[i]) ? ({1'b0, r_x} - {1'b0, ent_x_q[i]})
                                        : ({1'b0, ent_x_q[i]} - {1'b0, r_x});
            dy[i] = (r_y >= ent_y_q[i]) ? ({1'b0, r_y} - {1'b0, ent_y_q[i]})
                                        : ({1'b0, ent_y_q[i]} - {1'b0, r_y});
            if ((CW'(i) < count_q) && (dx[i] <= RADIUS_R) && (dy[i] <= RADIUS_R)
                && (ent_r_q[i] >= r_value)) begin
                suppress = 1'b1;
            end
        end
        for (int i = N - 1; i >= 0; i--) begin
            if ((CW'(i) >= count_q) || (r_value > ent_r_q[i])) begin
                ins_k = CW'(i);
            end
        end
        accept = is_cand && !suppress && (ins_k != CW'(N));
        for (int i = 0; i < N; i++) begin
            if (CW'(i) < ins_k) begin
                ins_x[i] = ent_x_q[i];
                ins_y[i] = ent_y_q[i];
                ins_r[i] = ent_r_q[i];
            end else if (CW'(i) == ins_k) begin
                ins_x[i] = r_x;
                ins_y[i] = r_y;
                ins_r[i] = r_value;
            end else begin
                ins_x[i] = ent_x_q[(i > 0) ? i - 1 : 0];
                ins_y[i] = ent_y_q[(i > 0) ? i - 1 : 0];
                ins_r[i] = ent_r_q[(i > 0) ? i - 1 : 0];
            end
        end
        ins_count = (count_q == CW'(N)) ? count_q : count_q + 1'b1;
    end

    // The publish snapshot is taken from the post-insert list, so a pixel arriving
    // together with the vsync edge still makes it into this frame's outputs.
    always_comb begin
        state_d        = state_q;
        vs_d           = VGA_VS;
        count_d        = count_q;
        corner_x_d     = corner_x_q;
        corner_y_d     = corner_y_q;
        corner_count_d = corner_count_q;
        frame_done_d   = 1'b0;
        for (int i = 0; i < N; i++) begin
            ent_x_d[i] = ent_x_q[i];
            ent_y_d[i] = ent_y_q[i];
            ent_r_d[i] = ent_r_q[i];
        end
        case (state_q)
            IDLE: begin
                if (vs_fall) begin
                    state_d = SCAN;
                    count_d = '0;
                    for (int i = 0; i < N; i++) begin
                        ent_x_d[i] = '0;
                        ent_y_d[i] = '0;
                        ent_r_d[i] = '0;
                    end
                end
            end
            SCAN: begin
                if (accept) begin
                    count_d = ins_count;
                    for (int i = 0; i < N; i++) begin
                        ent_x_d[i] = ins_x[i];
                        ent_y_d[i] = ins_y[i];
                        ent_r_d[i] = ins_r[i];
                    end
                end
                if (vs_fall) begin
                    state_d        = PUBLISH;
                    frame_done_d   = 1'b1;
                    corner_count_d = count_d;
                    for (int i = 0; i < N; i++) begin
                        corner_x_d[10*i +: 10] = (CW'(i) < count_d) ? ent_x_d[i] : 10'd0;
                        corner_y_d[10*i +: 10] = (CW'(i) < count_d) ? ent_y_d[i] : 10'd0;
                    end
                end
            end
            PUBLISH: begin
                state_d = SCAN;
                count_d = '0;
                for (int i = 0; i < N; i++) begin
                    ent_x_d[i] = '0;
                    ent_y_d[i] = '0;
                    ent_r_d[i] = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            vs_q           <= 1'b1;
            count_q        <= '0;
            corner_x_q     <= '0;
            corner_y_q     <= '0;
            corner_count_q <= '0;
            frame_done_q   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                ent_x_q[i] <= '0;
                ent_y_q[i] <= '0;
                ent_r_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            vs_q           <= vs_d;
            count_q        <= count_d;
            corner_x_q     <= corner_x_d;
            corner_y_q     <= corner_y_d;
            corner_count_q <= corner_count_d;
            frame_done_q   <= frame_done_d;
            for (int i = 0; i < N; i++) begin
                ent_x_q[i] <= ent_x_d[i];
                ent_y_q[i] <= ent_y_d[i];
                ent_r_q[i] <= ent_r_d[i];
            end
        end
    end

    assign corner_x     = corner_x_q;
    assign corner_y     = corner_y_q;
    assign corner_count = corner_count_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_harris_corner_select.sv
// Bench for harris_corner_select: directed frames plus random frames, each cycle
// compared against a queue-based model of the corner selection rules.
module tb_harris_corner_select;

    localparam int N      = 4;
    localparam int THRESH = 40;
    localparam int RADIUS = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               VGA_VS;
    logic               r_valid;
    logic signed [15:0] r_value;
    logic [9:0]         r_x;
    logic [9:0]         r_y;
    logic [39:0]        corner_x;
    logic [39:0]        corner_y;
    logic [2:0]         corner_count;
    logic               frame_done;

    always #5 clk = ~clk;

    harris_corner_select dut (
        .clk          (clk),
        .reset        (reset),
        .VGA_VS       (VGA_VS),
        .r_valid      (r_valid),
        .r_value      (r_value),
        .r_x          (r_x),
        .r_y          (r_y),
        .corner_x     (corner_x),
        .corner_y     (corner_y),
        .corner_count (corner_count),
        .frame_done   (frame_done)
    );

    typedef struct {
        int r;
        int x;
        int y;
    } ent_t;

    ent_t        lst[$];
    bit          armed;
    bit          pub_now;
    logic        prev_vs;
    logic [39:0] exp_x;
    logic [39:0] exp_y;
    logic [2:0]  exp_cnt;
    logic        exp_fd;
    int          checks = 0;
    int          passes = 0;

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    // Reference: strongest-first list, nearby equal-or-stronger entry blocks a candidate.
    task automatic model_pixel(input int r, input int x, input int y);
        int   pos;
        bit   sup;
        ent_t e;
        sup = 1'b0;
        if (r <= THRESH) return;
        foreach (lst[j]) begin
            if (absd(x, lst[j].x) <= RADIUS && absd(y, lst[j].y) <= RADIUS && lst[j].r >= r)
                sup = 1'b1;
        end
        if (sup) return;
        pos = lst.size();
        for (int j = 0; j < lst.size(); j++) begin
            if (r > lst[j].r) begin
                pos = j;
                break;
            end
        end
        if (pos >= N) return;
        e.r = r;
        e.x = x;
        e.y = y;
        lst.insert(pos, e);
        if (lst.size() > N) void'(lst.pop_back());
    endtask

    task automatic model_clock(input logic rst, input logic vs, input logic v,
                               input int r, input int x, input int y);
        bit fall;
        if (rst) begin
            lst.delete();
            armed   = 1'b0;
            pub_now = 1'b0;
            prev_vs = 1'b1;
            exp_x   = '0;
            exp_y   = '0;
            exp_cnt = '0;
            exp_fd  = 1'b0;
            return;
        end
        fall    = prev_vs && !vs;
        prev_vs = vs;
        exp_fd  = 1'b0;
        if (pub_now) begin
            lst.delete();
            pub_now = 1'b0;
        end else if (!armed) begin
            if (fall) begin
                armed = 1'b1;
                lst.delete();
            end
        end else begin
            if (v) model_pixel(r, x, y);
            if (fall) begin
                exp_x   = '0;
                exp_y   = '0;
                exp_cnt = 3'(lst.size());
                foreach (lst[j]) begin
                    exp_x[10*j +: 10] = 10'(lst[j].x);
                    exp_y[10*j +: 10] = 10'(lst[j].y);
                end
                exp_fd  = 1'b1;
                pub_now = 1'b1;
            end
        end
    endtask

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic checkOutput();
        checkVal("frame_done", {63'd0, frame_done}, {63'd0, exp_fd});
        checkVal("corner_count", {61'd0, corner_count}, {61'd0, exp_cnt});
        checkVal("corner_x", {24'd0, corner_x}, {24'd0, exp_x});
        checkVal("corner_y", {24'd0, corner_y}, {24'd0, exp_y});
    endtask

    task automatic applyStimulus(input logic rst, input logic vs, input logic v,
                                 input int r, input int x, input int y);
        reset   = rst;
        VGA_VS  = vs;
        r_valid = v;
        r_value = 16'(r);
        r_x     = 10'(x);
        r_y     = 10'(y);
        @(posedge clk);
        model_clock(rst, vs, v, r, x, y);
        #1;
        checkOutput();
    endtask

    task automatic pix(input int r, input int x, input int y);
        applyStimulus(1'b0, 1'b1, 1'b1, r, x, y);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b0, 0, 0, 0);
    endtask

    // One low cycle of VGA_VS, then a high cycle that may carry a pixel.
    task automatic vsync(input logic pv, input int r, input int x, input int y);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0);
        applyStimulus(1'b0, 1'b1, pv, r, x, y);
    endtask

    initial begin
        applyStimulus(1'b1, 1'b1, 1'b0, 0, 0, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 0, 0, 0);
        checkVal("reset_count", {61'd0, corner_count}, 64'd0);
        checkVal("reset_x", {24'd0, corner_x}, 64'd0);
        gap(2);

        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0);
        checkVal("first_vs_no_done", {63'd0, frame_done}, 64'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 0, 0, 0);
        gap(3);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0);
        checkVal("empty_done", {63'd0, frame_done}, 64'd1);
        checkVal("empty_count", {61'd0, corner_count}, 64'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 0, 0, 0);

        pix(100, 10, 10);
        pix(300, 50, 60);
        pix(200, 90, 20);
        pix(50, 5, 5);
        gap(1);
        vsync(1'b0, 0, 0, 0);
        checkVal("four_count", {61'd0, corner_count}, 64'd4);
        checkVal("four_x", {24'd0, corner_x}, {24'd0, 10'd5, 10'd10, 10'd90, 10'd50});
        checkVal("four_y", {24'd0, corner_y}, {24'd0, 10'd5, 10'd10, 10'd20, 10'd60});

        for (int i = 0; i < 6; i++) pix(41 + i, 20 * i + 5, 30);
        vsync(1'b0, 0, 0, 0);
        checkVal("six_count", {61'd0, corner_count}, 64'd4);
        checkVal("six_x", {24'd0, corner_x}, {24'd0, 10'd45, 10'd65, 10'd85, 10'd105});

        pix(40, 100, 100);
        pix(500, 200, 200);
        pix(400, 203, 197);
        pix(600, 202, 202);
        vsync(1'b0, 0, 0, 0);
        checkVal("supp_count", {61'd0, corner_count}, 64'd2);
        checkVal("supp_x", {24'd0, corner_x}, {24'd0, 10'd0, 10'd0, 10'd200, 10'd202});
        checkVal("supp_y", {24'd0, corner_y}, {24'd0, 10'd0, 10'd0, 10'd200, 10'd202});

        pix(80, 1, 1);
        pix(80, 300, 300);
        vsync(1'b1, 900, 400, 400);
        checkVal("tie_count", {61'd0, corner_count}, 64'd2);
        checkVal("tie_x", {24'd0, corner_x}, {24'd0, 10'd0, 10'd0, 10'd300, 10'd1});
        gap(2);
        vsync(1'b0, 0, 0, 0);
        checkVal("pub_pixel_dropped", {61'd0, corner_count}, 64'd0);

        pix(150, 20, 20);
        pix(160, 60, 60);
        applyStimulus(1'b1, 1'b1, 1'b0, 0, 0, 0);
        checkVal("midreset_count", {61'd0, corner_count}, 64'd0);
        checkVal("midreset_done", {63'd0, frame_done}, 64'd0);
        pix(170, 100, 100);
        vsync(1'b0, 0, 0, 0);
        pix(180, 7, 7);
        vsync(1'b0, 0, 0, 0);
        checkVal("postreset_count", {61'd0, corner_count}, 64'd1);
        checkVal("postreset_x", {24'd0, corner_x}, 64'd7);

        for (int f = 0; f < 6; f++) begin
            for (int p = 0; p < 40; p++) begin
                applyStimulus(1'b0, 1'b1, ($urandom % 4) != 0,
                              int'($urandom_range(0, 400)) - 100,
                              int'($urandom_range(0, 40)), int'($urandom_range(0, 40)));
            end
            vsync(($urandom % 2) != 0, int'($urandom_range(41, 400)),
                  int'($urandom_range(0, 40)), int'($urandom_range(0, 40)));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
